// File: rtl/sys_reg_file_nested_pkg.sv
// sys_reg_file_nested shared definitions.
// Register indices, PCS bit positions and the saved-context layout.
package sys_reg_file_nested_pkg;

  localparam logic [3:0] SR_PCS = 4'd0;
  localparam logic [3:0] SR_IDN = 4'd1;
  localparam logic [3:0] SR_IRA = 4'd2;
  localparam logic [3:0] SR_IHA = 4'd3;
  localparam logic [3:0] SR_IMR = 4'd4;
  localparam logic [3:0] SR_IPR = 4'd5;

  localparam int PCS_IE = 0;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pcs;
    logic [XLEN-1:0] ira;
  } ctx_t;

endpackage

// File: rtl/sys_reg_file_nested_ctx_stack.sv
// sys_reg_file_nested saved-context LIFO.
// Push when full and pop when empty are dropped.
module sys_reg_file_nested_ctx_stack #(
  parameter int W = 64,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] cntM1;
  logic          doPush;
  logic          doPop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty & ~push;
  assign cntM1  = count - CW'(1);
  assign dout   = mem[cntM1[AW-1:0]];

  // occupancy counter
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (doPush) begin
      count <= count + CW'(1);
    end else if (doPop) begin
      count <= cntM1;
    end
  end

  // entry storage, only the occupied region is ever read
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[count[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/sys_reg_file_nested.sv
// sys_reg_file_nested: system registers with nested fixed-priority IRQs.
// SYSREG_VECTORED_IRQ_EN selects one handler slot per source.
module sys_reg_file_nested
  import sys_reg_file_nested_pkg::*;
#(
  parameter int DBITS = 32,
  parameter int NUM_IRQ = 8,
  parameter int NEST_DEPTH = 4,
  parameter int VEC_SHIFT = 2,
  localparam int LW = $clog2(NEST_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sys_wrt_en,
  input  logic [3:0]         wrt_index,
  input  logic [3:0]         rd_index,
  input  logic [DBITS-1:0]   data_in,
  input  logic [DBITS-1:0]   pc_in,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               inta,
  input  logic               is_reti,
  output logic               irq_req,
  output logic               inta_sig,
  output logic [DBITS-1:0]   data_out,
  output logic [DBITS-1:0]   inta_addr,
  output logic [LW-1:0]      nest_level
);

  localparam int SW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic [DBITS-1:0]   pcs;
  logic [DBITS-1:0]   idn;
  logic [DBITS-1:0]   ira;
  logic [DBITS-1:0]   iha;
  logic [DBITS-1:0]   imr;
  logic [NUM_IRQ-1:0] ipr;
  logic [NUM_IRQ-1:0] iprNext;
  logic [NUM_IRQ-1:0] irqPrev;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] selMask;
  logic [NUM_IRQ-1:0] clrMask;
  logic [SW-1:0]      sel;
  logic [DBITS-1:0]   handler;
  logic [2*DBITS-1:0] popData;
  logic               full;
  logic               empty;
  logic               doPop;
  logic               wrPcs;
  logic               wrIdn;
  logic               wrIra;
  logic               wrIha;
  logic               wrImr;
  logic               wrIpr;

  assign wrPcs = sys_wrt_en & (wrt_index == SR_PCS);
  assign wrIdn = sys_wrt_en & (wrt_index == SR_IDN);
  assign wrIra = sys_wrt_en & (wrt_index == SR_IRA);
  assign wrIha = sys_wrt_en & (wrt_index == SR_IHA);
  assign wrImr = sys_wrt_en & (wrt_index == SR_IMR);
  assign wrIpr = sys_wrt_en & (wrt_index == SR_IPR);

  assign rise     = irq_in & ~irqPrev;
  assign eligible = ipr & imr[NUM_IRQ-1:0];
  assign irq_req  = pcs[PCS_IE] & (|eligible) & ~full & ~is_reti;
  assign inta_sig = inta & irq_req;
  assign doPop    = is_reti & ~empty;

  // lowest index wins
  always_comb begin
    sel = '0;
    selMask = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel = SW'(i);
        selMask = NUM_IRQ'(1) << i;
      end
    end
  end

  // a new edge beats a take or W1C clear of the same bit
  always_comb begin
    clrMask = '0;
    if (inta_sig) clrMask = clrMask | selMask;
    if (wrIpr) clrMask = clrMask | data_in[NUM_IRQ-1:0];
    iprNext = (ipr & ~clrMask) | rise;
  end

`ifdef SYSREG_VECTORED_IRQ_EN
  assign handler = (iha + DBITS'(sel)) << VEC_SHIFT;
`else
  assign handler = iha << VEC_SHIFT;
`endif

  assign inta_addr = inta_sig ? handler : ira;

  sys_reg_file_nested_ctx_stack #(
    .W     (2 * DBITS),
    .DEPTH (NEST_DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (inta_sig),
    .pop   (doPop),
    .din   ({pcs, ira}),
    .dout  (popData),
    .full  (full),
    .empty (empty),
    .count (nest_level)
  );

  // register state: take, then pop, then WSR
  always_ff @(posedge clk) begin
    if (reset) begin
      pcs     <= '0;
      idn     <= '0;
      ira     <= '0;
      iha     <= '0;
      imr     <= '0;
      ipr     <= '0;
      irqPrev <= '0;
    end else begin
      irqPrev <= irq_in;
      ipr     <= iprNext;
      if (inta_sig) pcs <= '0;
      else if (doPop) pcs <= popData[2*DBITS-1:DBITS];
      else if (wrPcs) pcs <= data_in;
      if (inta_sig) ira <= pc_in;
      else if (doPop) ira <= popData[DBITS-1:0];
      else if (wrIra) ira <= data_in;
      if (inta_sig) idn <= DBITS'(sel);
      else if (wrIdn) idn <= data_in;
      if (wrIha) iha <= data_in;
      if (wrImr) imr <= data_in;
    end
  end

  // RSR read with same-cycle WSR bypass
  always_comb begin
    data_out = '0;
    unique case (1'b1)
      (rd_index == SR_PCS): data_out = pcs;
      (rd_index == SR_IDN): data_out = idn;
      (rd_index == SR_IRA): data_out = ira;
      (rd_index == SR_IHA): data_out = iha;
      (rd_index == SR_IMR): data_out = imr;
      (rd_index == SR_IPR): data_out = DBITS'(ipr);
      default:              data_out = '0;
    endcase
    if (sys_wrt_en && (wrt_index == rd_index) && (rd_index <= SR_IPR)) begin
      if (rd_index == SR_IPR) data_out = DBITS'(iprNext);
      else data_out = data_in;
    end
  end

endmodule

// File: tb/tb_sys_reg_file_nested.sv
// sys_reg_file_nested directed bench.
// Build with SYSREG_VECTORED_IRQ_EN to exercise per-source vectors.
module tb_sys_reg_file_nested;

  logic        clk;
  logic        reset;
  logic        sys_wrt_en;
  logic [3:0]  wrt_index;
  logic [3:0]  rd_index;
  logic [31:0] data_in;
  logic [31:0] pc_in;
  logic [7:0]  irq_in;
  logic        inta;
  logic        is_reti;
  logic        irq_req;
  logic        inta_sig;
  logic [31:0] data_out;
  logic [31:0] inta_addr;
  logic [2:0]  nest_level;

  int nCmp = 0;
  int nBad = 0;
  logic [31:0] v;

`ifdef SYSREG_VECTORED_IRQ_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif

  sys_reg_file_nested dut (
    .clk        (clk),
    .reset      (reset),
    .sys_wrt_en (sys_wrt_en),
    .wrt_index  (wrt_index),
    .rd_index   (rd_index),
    .data_in    (data_in),
    .pc_in      (pc_in),
    .irq_in     (irq_in),
    .inta       (inta),
    .is_reti    (is_reti),
    .irq_req    (irq_req),
    .inta_sig   (inta_sig),
    .data_out   (data_out),
    .inta_addr  (inta_addr),
    .nest_level (nest_level)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [31:0] hAddr(input int s);
    return VEC ? ((32'h40 + 32'(s)) << 2) : 32'h100;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rsr(input logic [3:0] idx, output logic [31:0] val);
    rd_index = idx;
    #1;
    val = data_out;
  endtask

  task automatic wsr(input logic [3:0] idx, input logic [31:0] val);
    sys_wrt_en = 1'b1;
    wrt_index = idx;
    data_in = val;
    step();
    sys_wrt_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    sys_wrt_en = 1'b0;
    wrt_index = '0;
    rd_index = '0;
    data_in = '0;
    pc_in = '0;
    irq_in = '0;
    inta = 1'b0;
    is_reti = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      rsr(4'(i), v);
      chk($sformatf("rst_rsr%0d", i), v, 32'h0);
    end
    chk("rst_req", 32'(irq_req), 32'h0);
    chk("rst_nest", 32'(nest_level), 32'h0);
    chk("rst_addr", inta_addr, 32'h0);

    wsr(4'd3, 32'h40);
    wsr(4'd4, 32'hFF);
    wsr(4'd0, 32'h1);
    irq_in = 8'h08;
    step();
    irq_in = 8'h00;
    #1;
    chk("t1_req", 32'(irq_req), 32'h1);
    inta = 1'b1;
    pc_in = 32'h100;
    #1;
    chk("t1_sig", 32'(inta_sig), 32'h1);
    chk("t1_addr", inta_addr, hAddr(3));
    step();
    inta = 1'b0;
    rsr(4'd1, v); chk("t1_idn", v, 32'h3);
    rsr(4'd2, v); chk("t1_ira", v, 32'h100);
    rsr(4'd0, v); chk("t1_pcs", v, 32'h0);
    rsr(4'd5, v); chk("t1_ipr", v, 32'h0);
    chk("t1_nest", 32'(nest_level), 32'h1);
    chk("t1_iaddr", inta_addr, 32'h100);
    is_reti = 1'b1;
    #1;
    chk("t1_reti_addr", inta_addr, 32'h100);
    step();
    is_reti = 1'b0;
    rsr(4'd0, v); chk("t1_pcs_rest", v, 32'h1);
    rsr(4'd2, v); chk("t1_ira_rest", v, 32'h0);
    chk("t1_nest0", 32'(nest_level), 32'h0);

    irq_in = 8'h24;
    step();
    irq_in = 8'h00;
    inta = 1'b1;
    pc_in = 32'h200;
    #1;
    chk("t2_addr", inta_addr, hAddr(2));
    step();
    inta = 1'b0;
    rsr(4'd1, v); chk("t2_idn", v, 32'h2);
    rsr(4'd5, v); chk("t2_ipr", v, 32'h20);
    chk("t2_req_ie0", 32'(irq_req), 32'h0);
    is_reti = 1'b1;
    step();
    is_reti = 1'b0;
    #1;
    chk("t2_req5", 32'(irq_req), 32'h1);
    inta = 1'b1;
    pc_in = 32'h300;
    step();
    inta = 1'b0;
    rsr(4'd1, v); chk("t2_idn5", v, 32'h5);
    rsr(4'd5, v); chk("t2_ipr0", v, 32'h0);
    rsr(4'd2, v); chk("t2_ira", v, 32'h300);
    is_reti = 1'b1;
    step();
    is_reti = 1'b0;

    for (int k = 0; k < 4; k++) begin
      irq_in = 8'(1 << k);
      step();
      irq_in = 8'h00;
      inta = 1'b1;
      pc_in = 32'h1000 + 32'(16 * k);
      step();
      inta = 1'b0;
      wsr(4'd0, 32'h1);
    end
    #1;
    chk("t3_nest4", 32'(nest_level), 32'h4);
    irq_in = 8'h40;
    step();
    irq_in = 8'h00;
    #1;
    chk("t3_full_req", 32'(irq_req), 32'h0);
    rsr(4'd5, v); chk("t3_ipr6", v, 32'h40);
    for (int k = 3; k >= 0; k--) begin
      is_reti = 1'b1;
      #1;
      chk($sformatf("t3_pop%0d", k), inta_addr, 32'h1000 + 32'(16 * k));
      step();
      is_reti = 1'b0;
    end
    #1;
    chk("t3_nest0", 32'(nest_level), 32'h0);
    rsr(4'd2, v); chk("t3_ira0", v, 32'h0);
    rsr(4'd0, v); chk("t3_pcs1", v, 32'h1);

    sys_wrt_en = 1'b1;
    wrt_index = 4'd4;
    data_in = 32'h0F;
    rd_index = 4'd4;
    #1;
    chk("t4_imr_byp", data_out, 32'h0F);
    step();
    sys_wrt_en = 1'b0;
    #1;
    chk("t4_req_masked", 32'(irq_req), 32'h0);
    sys_wrt_en = 1'b1;
    wrt_index = 4'd5;
    data_in = 32'h04;
    rd_index = 4'd5;
    irq_in = 8'h04;
    #1;
    chk("t4_ipr_byp", data_out, 32'h44);
    step();
    sys_wrt_en = 1'b0;
    irq_in = 8'h00;
    rsr(4'd5, v); chk("t4_ipr_setwins", v, 32'h44);
    chk("t4_req2", 32'(irq_req), 32'h1);
    wsr(4'd5, 32'h44);
    rsr(4'd5, v); chk("t4_ipr_clr", v, 32'h0);
    rsr(4'd7, v); chk("t4_unmapped", v, 32'h0);

    wsr(4'd2, 32'h55);
    is_reti = 1'b1;
    step();
    is_reti = 1'b0;
    rsr(4'd0, v); chk("t5_pcs_keep", v, 32'h1);
    rsr(4'd2, v); chk("t5_ira_keep", v, 32'h55);
    chk("t5_nest0", 32'(nest_level), 32'h0);
    irq_in = 8'h02;
    step();
    irq_in = 8'h00;
    inta = 1'b1;
    pc_in = 32'h700;
    step();
    inta = 1'b0;
    #1;
    chk("t5_nest1", 32'(nest_level), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("t5_rst_nest", 32'(nest_level), 32'h0);
    rsr(4'd0, v); chk("t5_rst_pcs", v, 32'h0);
    rsr(4'd2, v); chk("t5_rst_ira", v, 32'h0);
    rsr(4'd4, v); chk("t5_rst_imr", v, 32'h0);
    chk("t5_rst_req", 32'(irq_req), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
